// File: rtl/br_pkg.sv
// Shared constants for the branch resolution unit: opcodes, FSM state encoding, default width.
package br_pkg;

    localparam int BR_DATA_W = 32;
    localparam int BR_OP_W   = 3;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator; one zero-detect serves rs and rs^rt.
module br_cond_eval
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W,
    parameter int OP_W   = BR_OP_W
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic              taken_o
);

    function automatic logic zero_det(input logic [DATA_W-1:0] v);
        zero_det = (v == {DATA_W{1'b0}});
    endfunction

    logic rs_zero_s;
    logic rs_eq_rt_s;
    logic rs_neg_s;

    assign rs_zero_s  = zero_det(rs_i);
    assign rs_eq_rt_s = zero_det(rs_i ^ rt_i);
    assign rs_neg_s   = rs_i[DATA_W-1];

    // Decode opcode into the taken decision; reserved opcodes never branch.
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BR_BEQ:  taken_o = rs_eq_rt_s;
            BR_BNE:  taken_o = ~rs_eq_rt_s;
            BR_BLEZ: taken_o = rs_zero_s | rs_neg_s;
            BR_BGTZ: taken_o = ~rs_zero_s & ~rs_neg_s;
            BR_BLTZ: taken_o = rs_neg_s;
            BR_BGEZ: taken_o = ~rs_neg_s;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution at ID/EX: accept, wait for forwarded operands, present registered result.
// Optional BR_STATS_EN adds saturating taken/not-taken counters.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int DATA_W = BR_DATA_W,
    parameter int OP_W   = BR_OP_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [OP_W-1:0]   br_op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] imm,
    input  logic              opnd_pending,
    input  logic              squash,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              taken,
    output logic [DATA_W-1:0] target,
`ifdef BR_STATS_EN
    output logic [31:0]       stat_taken,
    output logic [31:0]       stat_not_taken,
`endif
    output logic              flush
);

    br_state_e         state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic              taken_q;
    logic [DATA_W-1:0] target_q;

    logic              accept_s;
    logic              load_res_s;
    logic              consume_s;
    logic              cond_taken_s;
    logic [OP_W-1:0]   eval_op_s;

    // In IDLE the opcode is still on the input bus; in WAIT it comes from the capture register.
    assign eval_op_s = (state_q == ST_IDLE) ? br_op : op_q;

    br_cond_eval #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_cond (
        .op_i    (eval_op_s),
        .rs_i    (rs_val),
        .rt_i    (rt_val),
        .taken_o (cond_taken_s)
    );

    // Next-state logic; squash overrides every transition.
    always_comb begin
        state_d    = state_q;
        accept_s   = 1'b0;
        load_res_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (br_valid) begin
                    accept_s = 1'b1;
                    if (opnd_pending) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESULT;
                        load_res_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!opnd_pending) begin
                    state_d    = ST_RESULT;
                    load_res_s = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESULT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (squash) begin
            state_d    = ST_IDLE;
            accept_s   = 1'b0;
            load_res_s = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and captured branch fields.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= {OP_W{1'b0}};
            taken_q  <= 1'b0;
            target_q <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            if (accept_s) begin
                op_q     <= br_op;
                target_q <= pc_plus4 + (imm << 2);
            end
            if (squash || consume_s) begin
                taken_q <= 1'b0;
            end else if (load_res_s) begin
                taken_q <= cond_taken_s;
            end
        end
    end

    assign br_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_RESULT);
    assign taken     = taken_q;
    assign target    = target_q;
    assign consume_s = res_valid & res_ready & ~squash;
    assign flush     = consume_s & taken_q;

`ifdef BR_STATS_EN
    logic [31:0] stat_taken_q;
    logic [31:0] stat_not_taken_q;

    // Saturating outcome counters, stepped once per consumed result.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stat_taken_q     <= 32'd0;
            stat_not_taken_q <= 32'd0;
        end else if (consume_s) begin
            if (taken_q && (stat_taken_q != 32'hFFFF_FFFF)) begin
                stat_taken_q <= stat_taken_q + 32'd1;
            end
            if (!taken_q && (stat_not_taken_q != 32'hFFFF_FFFF)) begin
                stat_not_taken_q <= stat_not_taken_q + 32'd1;
            end
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches queue hand-computed results for a monitor.
module tb_branch_resolve_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    logic [2:0]  br_op = 3'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic [31:0] pc_plus4 = 32'd0;
    logic [31:0] imm = 32'd0;
    logic        opnd_pending = 1'b0;
    logic        squash = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        taken;
    logic [31:0] target;
    logic        flush;
`ifdef BR_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
`endif

    typedef struct packed {
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    branch_resolve_unit dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_op        (br_op),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .pc_plus4     (pc_plus4),
        .imm          (imm),
        .opnd_pending (opnd_pending),
        .squash       (squash),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .taken        (taken),
        .target       (target),
`ifdef BR_STATS_EN
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
`endif
        .flush        (flush)
    );

    always #5 Clk = ~Clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: pop and compare on every handshake; otherwise flush must be low.
    always @(negedge Clk) begin
        exp_t e;
        if (res_valid && res_ready && !squash) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result taken=%0b target=0x%08h", taken, target);
            end else begin
                e = exp_q.pop_front();
                chk("sb_taken", {31'd0, taken}, {31'd0, e.tk});
                chk("sb_target", target, e.tgt);
                chk("sb_flush", {31'd0, flush}, {31'd0, e.tk});
            end
        end else begin
            chk("flush_idle", {31'd0, flush}, 32'd0);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Issue one branch: pend cycles of pending (with wait_rs on the bus), then hold cycles of res_ready=0.
    task automatic send(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc, input logic [31:0] im, input int pend,
                        input logic [31:0] wait_rs, input int hold,
                        input logic exp_tk, input logic [31:0] exp_tgt);
        exp_t e;
        e.tk  = exp_tk;
        e.tgt = exp_tgt;
        exp_q.push_back(e);
        chk("ready_before_accept", {31'd0, br_ready}, 32'd1);
        br_valid     = 1'b1;
        br_op        = op;
        rs_val       = (pend > 0) ? wait_rs : rs;
        rt_val       = rt;
        pc_plus4     = pc;
        imm          = im;
        opnd_pending = (pend > 0);
        res_ready    = (hold == 0);
        step();
        br_valid = 1'b0;
        for (int i = 0; i < pend; i++) begin
            chk("wait_ready_low", {31'd0, br_ready}, 32'd0);
            chk("wait_no_valid", {31'd0, res_valid}, 32'd0);
            rs_val       = (i == pend - 1) ? rs : (wait_rs + i[31:0]);
            opnd_pending = (i != pend - 1);
            if (i == pend - 1) begin
                rs_val = rs;
            end else begin
                rs_val = wait_rs + i[31:0];
            end
            step();
        end
        chk("latency_valid", {31'd0, res_valid}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            br_valid = 1'b1;
            chk("hold_ready_low", {31'd0, br_ready}, 32'd0);
            chk("hold_taken", {31'd0, taken}, {31'd0, exp_tk});
            chk("hold_target", target, exp_tgt);
            step();
        end
        br_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        chk("back_to_idle", {31'd0, br_ready}, 32'd1);
        res_ready = 1'b0;
    endtask

    initial begin
        #12;
        Rst_n = 1'b1;
        step();
        chk("rst_ready", {31'd0, br_ready}, 32'd1);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);

        // op, rs, rt, pc, imm, pend, wait_rs, hold, taken, target
        send(3'b000, 32'h0000_1234, 32'h0000_1234, 32'h0040_0010, 32'h0000_0004, 0, 32'd0, 0, 1'b1, 32'h0040_0020);
        send(3'b011, 32'h8000_0000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0010, 0, 32'd0, 0, 1'b0, 32'h0000_1040);
        send(3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_2000, 32'hFFFF_FFFE, 0, 32'd0, 0, 1'b1, 32'h0000_1FF8);
        send(3'b001, 32'h0000_0078, 32'h0000_0077, 32'h0000_0100, 32'h0000_0001, 3, 32'h0000_0077, 0, 1'b1, 32'h0000_0104);
        send(3'b100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_3000, 32'h0000_0003, 0, 32'd0, 4, 1'b1, 32'h0000_300C);
        send(3'b101, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 32'd0, 0, 1'b1, 32'hFFFF_FFFC);
        send(3'b110, 32'h0000_0000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0000, 0, 32'd0, 0, 1'b0, 32'h0000_0010);
        send(3'b000, 32'h0000_0001, 32'h0000_0002, 32'h0000_0020, 32'h0000_0002, 0, 32'd0, 0, 1'b0, 32'h0000_0028);
        send(3'b010, 32'h0000_0001, 32'h0000_0000, 32'h0000_0030, 32'h0000_0000, 0, 32'd0, 0, 1'b0, 32'h0000_0030);

        // Squash while waiting for operands.
        res_ready    = 1'b1;
        br_valid     = 1'b1;
        br_op        = 3'b001;
        rs_val       = 32'd1;
        rt_val       = 32'd2;
        opnd_pending = 1'b1;
        step();
        br_valid = 1'b0;
        chk("sq_wait_state", {31'd0, br_ready}, 32'd0);
        squash = 1'b1;
        step();
        squash       = 1'b0;
        opnd_pending = 1'b0;
        chk("sq_wait_idle", {31'd0, br_ready}, 32'd1);
        step();
        chk("sq_wait_no_valid", {31'd0, res_valid}, 32'd0);

        // Squash coincident with a request in IDLE.
        br_valid = 1'b1;
        squash   = 1'b1;
        step();
        br_valid = 1'b0;
        squash   = 1'b0;
        chk("sq_idle_ready", {31'd0, br_ready}, 32'd1);
        chk("sq_idle_no_valid", {31'd0, res_valid}, 32'd0);
        step();
        chk("sq_idle_no_valid2", {31'd0, res_valid}, 32'd0);
        res_ready = 1'b0;

`ifdef BR_STATS_EN
        chk("stat_taken", stat_taken, 32'd5);
        chk("stat_not_taken", stat_not_taken, 32'd4);
`endif

        // Asynchronous reset pulse while in WAIT.
        br_valid     = 1'b1;
        br_op        = 3'b000;
        pc_plus4     = 32'h0000_0040;
        imm          = 32'h0000_0000;
        opnd_pending = 1'b1;
        step();
        br_valid = 1'b0;
        chk("rw_target_loaded", target, 32'h0000_0040);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("rw_ready", {31'd0, br_ready}, 32'd1);
        chk("rw_valid", {31'd0, res_valid}, 32'd0);
        chk("rw_taken", {31'd0, taken}, 32'd0);
        chk("rw_target", target, 32'd0);
        chk("rw_flush", {31'd0, flush}, 32'd0);
`ifdef BR_STATS_EN
        chk("rw_stat_taken", stat_taken, 32'd0);
        chk("rw_stat_not_taken", stat_not_taken, 32'd0);
`endif
        #2;
        Rst_n        = 1'b1;
        opnd_pending = 1'b0;
        step();

        send(3'b011, 32'h0000_0005, 32'h0000_0000, 32'h0000_0200, 32'h0000_0008, 0, 32'd0, 0, 1'b1, 32'h0000_0220);

        step();
        step();
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
